mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto a single
// memory port with one transaction in flight. Build option: ARB_ROUND_ROBIN_EN.

`ifndef XLEN
`define XLEN 32
`endif

module mem_port_arbiter (
  input  logic               clk,
  input  logic               rst,

  input  logic               if_req,
  input  logic [`XLEN-1:0]   if_addr,
  input  logic               if_kill,
  output logic               if_gnt,
  output logic               if_rvalid,
  output logic [`XLEN-1:0]   if_rdata,

  input  logic               ls_req,
  input  logic               ls_we,
  input  logic [3:0]         ls_wstrb,
  input  logic [`XLEN-1:0]   ls_addr,
  input  logic [`XLEN-1:0]   ls_wdata,
  output logic               ls_gnt,
  output logic               ls_rvalid,
  output logic [`XLEN-1:0]   ls_rdata,

  output logic               mem_req,
  output logic               mem_we,
  output logic [3:0]         mem_wstrb,
  output logic [`XLEN-1:0]   mem_addr,
  output logic [`XLEN-1:0]   mem_wdata,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [`XLEN-1:0]   mem_rdata,

  output logic               busy
);

  localparam int unsigned XLEN_W = `XLEN;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2
  } state_t;

  state_t              state;
  logic                owner_ls;
  logic                discard;
  logic                pick_ls;
  logic                gnt_hit;
  logic                rsp_hit;
  logic [XLEN_W-1:0]   if_rdata_q;
  logic [XLEN_W-1:0]   ls_rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic                last_ls;

  // On a tie the requester that did not win last time takes the port.
  always_comb begin
    pick_ls = 1'b0;
    if (ls_req && if_req) pick_ls = ~last_ls;
    else                  pick_ls = ls_req;
  end
`else
  // Load/store always wins a tie.
  always_comb begin
    pick_ls = ls_req;
  end
`endif

  // Grant and response strobes follow the memory handshake in the same cycle.
  always_comb begin
    gnt_hit   = (state == S_REQ) && mem_gnt;
    rsp_hit   = (state == S_RSP) && mem_rvalid;
    if_gnt    = gnt_hit && !owner_ls;
    ls_gnt    = gnt_hit && owner_ls;
    if_rvalid = rsp_hit && !owner_ls && !discard && !if_kill;
    ls_rvalid = rsp_hit && owner_ls;
    if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
    ls_rdata  = ls_rvalid ? mem_rdata : ls_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner_ls   <= 1'b0;
      discard    <= 1'b0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_wstrb  <= STRB_W'(0);
      mem_addr   <= XLEN_W'(0);
      mem_wdata  <= XLEN_W'(0);
      if_rdata_q <= XLEN_W'(0);
      ls_rdata_q <= XLEN_W'(0);
`ifdef ARB_ROUND_ROBIN_EN
      last_ls    <= 1'b1;
`endif
    end else begin
      if (if_rvalid) if_rdata_q <= mem_rdata;
      if (ls_rvalid) ls_rdata_q <= mem_rdata;

      case (state)
        S_IDLE: begin
          if (if_req || ls_req) begin
            state    <= S_REQ;
            busy     <= 1'b1;
            mem_req  <= 1'b1;
            owner_ls <= pick_ls;
            if (pick_ls) begin
              mem_we    <= ls_we;
              mem_wstrb <= ls_wstrb;
              mem_addr  <= ls_addr;
              mem_wdata <= ls_wdata;
            end else begin
              mem_we    <= 1'b0;
              mem_wstrb <= STRB_W'(0);
              mem_addr  <= if_addr;
              mem_wdata <= XLEN_W'(0);
            end
          end
        end

        S_REQ: begin
          if (if_kill && !owner_ls) discard <= 1'b1;
          if (mem_gnt) begin
            state   <= S_RSP;
            mem_req <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_ls <= owner_ls;
`endif
          end
        end

        S_RSP: begin
          if (if_kill && !owner_ls) discard <= 1'b1;
          // Returning to IDLE does not arbitrate in the same cycle.
          if (mem_rvalid) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            discard <= 1'b0;
          end
        end

        default: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
          discard <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_kill, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [3:0]  ls_wstrb;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_if;
  logic        exp_ls;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_wstrb(ls_wstrb), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    if_req = 0; if_addr = 0; if_kill = 0;
    ls_req = 0; ls_we = 0; ls_wstrb = 0; ls_addr = 0; ls_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    cyc; cyc;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    chk("rst_strobes", 32'({if_gnt, ls_gnt, if_rvalid, ls_rvalid}), 0);
    rst = 1'b0;

    // Single fetch, immediate grant, response two cycles after the request.
    if_req = 1; if_addr = 32'h8000_0000;
    #1 chk("t1_c0_busy", 32'(busy), 0);
    chk("t1_c0_mem_req", 32'(mem_req), 0);
    cyc; mem_gnt = 1;
    #1 chk("t1_c1_mem_req", 32'(mem_req), 1);
    chk("t1_c1_addr", mem_addr, 32'h8000_0000);
    chk("t1_c1_we", 32'(mem_we), 0);
    chk("t1_c1_wstrb", 32'(mem_wstrb), 0);
    chk("t1_c1_if_gnt", 32'(if_gnt), 1);
    chk("t1_c1_ls_gnt", 32'(ls_gnt), 0);
    chk("t1_c1_busy", 32'(busy), 1);
    cyc; if_req = 0; mem_gnt = 0;
    #1 chk("t1_c2_mem_req", 32'(mem_req), 0);
    chk("t1_c2_if_gnt", 32'(if_gnt), 0);
    chk("t1_c2_if_rvalid", 32'(if_rvalid), 0);
    cyc; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
    #1 chk("t1_c3_if_rvalid", 32'(if_rvalid), 1);
    chk("t1_c3_if_rdata", if_rdata, 32'h13);
    chk("t1_c3_ls_rvalid", 32'(ls_rvalid), 0);
    last_if = 32'h13;
    cyc; mem_rvalid = 0; mem_rdata = 32'hFFFF_FFFF; mem_gnt = 1;
    #1 chk("t1_c4_if_rvalid", 32'(if_rvalid), 0);
    chk("t1_c4_rdata_hold", if_rdata, 32'h13);
    chk("t1_c4_busy", 32'(busy), 0);
    chk("t1_c4_idle_gnt", 32'({if_gnt, ls_gnt}), 0);
    cyc; mem_gnt = 0;
    #1 chk("t1_c5_busy", 32'(busy), 0);
    chk("t1_c5_mem_req", 32'(mem_req), 0);

    // Store with grant delayed three cycles; later attribute changes ignored.
    ls_req = 1; ls_we = 1; ls_wstrb = 4'hF; ls_addr = 32'h8000_0100; ls_wdata = 32'hDEAD_BEEF;
    cyc;
    for (int i = 0; i < 4; i++) begin
      mem_gnt = (i == 3);
      #1 chk("t2_mem_req", 32'(mem_req), 1);
      chk("t2_addr", mem_addr, 32'h8000_0100);
      chk("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("t2_we", 32'(mem_we), 1);
      chk("t2_wstrb", 32'(mem_wstrb), 32'hF);
      chk("t2_ls_gnt", 32'(ls_gnt), 32'(i == 3));
      chk("t2_if_gnt", 32'(if_gnt), 0);
      if (i == 0) ls_addr = 32'h0;
      cyc;
    end
    ls_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0600; if_kill = 1;
    #1 chk("t2_ls_rvalid", 32'(ls_rvalid), 1);
    chk("t2_ls_rdata", ls_rdata, 32'h600);
    chk("t2_if_rvalid", 32'(if_rvalid), 0);
    chk("t2_mem_req_rsp", 32'(mem_req), 0);
    chk("t2_ls_gnt_rsp", 32'(ls_gnt), 0);
    cyc; mem_rvalid = 0; if_kill = 0; mem_rdata = 32'h5A5A_5A5A;
    #1 chk("t2_busy_idle", 32'(busy), 0);
    chk("t2_ls_rdata_hold", ls_rdata, 32'h600);

    // Both requesters asserted continuously across two transactions.
    if_req = 1; ls_req = 1; if_addr = 32'h1000; ls_addr = 32'h2000; ls_we = 0; ls_wstrb = 0;
    for (int k = 0; k < 2; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_ls = (k == 1);
`else
      exp_ls = 1'b1;
`endif
      cyc; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hBAD;
      #1 chk("t3_addr", mem_addr, exp_ls ? 32'h2000 : 32'h1000);
      chk("t3_ls_gnt", 32'(ls_gnt), 32'(exp_ls));
      chk("t3_if_gnt", 32'(if_gnt), 32'(!exp_ls));
      chk("t3_rvalid_in_req", 32'({if_rvalid, ls_rvalid}), 0);
      cyc; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hA0 + 32'(k);
      if (k == 1) begin if_req = 0; ls_req = 0; end
      #1 chk("t3_ls_rvalid", 32'(ls_rvalid), 32'(exp_ls));
      chk("t3_if_rvalid", 32'(if_rvalid), 32'(!exp_ls));
      if (!exp_ls) last_if = 32'hA0 + 32'(k);
      cyc; mem_rvalid = 0;
    end
    #1 chk("t3_busy_end", 32'(busy), 0);

    // Killed fetch: handshake completes, response suppressed, next fetch normal.
    if_req = 1; if_addr = 32'h100;
    cyc; mem_gnt = 1;
    #1 chk("t4_if_gnt", 32'(if_gnt), 1);
    cyc; if_req = 0; mem_gnt = 0; if_kill = 1;
    #1 chk("t4_kill_rvalid", 32'(if_rvalid), 0);
    cyc; if_kill = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    #1 chk("t4_discard_rvalid", 32'(if_rvalid), 0);
    chk("t4_discard_rdata", if_rdata, last_if);
    chk("t4_busy_rsp", 32'(busy), 1);
    cyc; mem_rvalid = 0; if_req = 1; if_addr = 32'h104;
    #1 chk("t4_busy_idle", 32'(busy), 0);
    cyc; mem_gnt = 1;
    #1 chk("t4_next_addr", mem_addr, 32'h104);
    chk("t4_next_gnt", 32'(if_gnt), 1);
    cyc; if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h55;
    #1 chk("t4_next_rvalid", 32'(if_rvalid), 1);
    chk("t4_next_rdata", if_rdata, 32'h55);
    cyc; mem_rvalid = 0;

    // Reset during the response phase, late memory response ignored.
    ls_req = 1; ls_we = 0; ls_addr = 32'h200;
    cyc; mem_gnt = 1;
    #1 chk("t5_ls_gnt", 32'(ls_gnt), 1);
    cyc; ls_req = 0; mem_gnt = 0; rst = 1;
    cyc; rst = 0;
    #1 chk("t5_busy", 32'(busy), 0);
    chk("t5_mem_req", 32'(mem_req), 0);
    chk("t5_mem_addr", mem_addr, 0);
    chk("t5_ls_rdata", ls_rdata, 0);
    chk("t5_if_rdata", if_rdata, 0);
    cyc; mem_rvalid = 1; mem_rdata = 32'h77;
    #1 chk("t5_late_rvalid", 32'({if_rvalid, ls_rvalid}), 0);
    chk("t5_late_rdata", ls_rdata, 0);
    chk("t5_late_busy", 32'(busy), 0);
    cyc; mem_rvalid = 0;
    #1 chk("t5_end_busy", 32'(busy), 0);
    chk("t5_end_mem_req", 32'(mem_req), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
